// File: rtl/pwm_pkg.sv
// Shared constants, types and helpers for the multi-channel PWM block.
package pwm_pkg;

  localparam int NUM_CH_DEF  = 16;
  localparam int CNT_W_DEF   = 8;
  localparam int PRESC_W_DEF = 8;

  typedef enum logic {
    PWM_MODE_STATIC = 1'b0,
    PWM_MODE_PWM    = 1'b1
  } pwm_mode_e;

  function automatic int unsigned cnt_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/pwm_multi_channel_if.sv
// Configuration and output bundle between the register file (master) and the PWM block (slave).
interface pwm_multi_channel_if
  import pwm_pkg::*;
#(
  parameter int NUM_CH  = NUM_CH_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int PRESC_W = PRESC_W_DEF
);

  logic [NUM_CH-1:0]       en_out;
  logic [NUM_CH-1:0]       en_pwm;
  logic [NUM_CH*CNT_W-1:0] duty;
  logic [PRESC_W-1:0]      prescale;
  logic                    cfg_load;
  logic                    cfg_pending;
  logic                    period_start;
  logic [NUM_CH-1:0]       pwm_out;

  modport master (
    output en_out, en_pwm, duty, prescale, cfg_load,
    input  cfg_pending, period_start, pwm_out
  );

  modport slave (
    input  en_out, en_pwm, duty, prescale, cfg_load,
    output cfg_pending, period_start, pwm_out
  );

endinterface

// File: rtl/pwm_timebase.sv
// Shared prescaler and period counter; produces the boundary strobe and period_start pulse.
// PWM_CENTER_ALIGNED_EN selects an up/down counter instead of the edge-aligned up-counter.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int PRESC_W = PRESC_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PRESC_W-1:0] prescale_i,
  output logic [CNT_W-1:0]   cnt_o,
  output logic               boundary_o,
  output logic               period_start_o
);

  localparam logic [CNT_W-1:0] MAX = CNT_W'(cnt_max(CNT_W));

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               period_start_q;
  logic               tick;
  logic               boundary;

  // >= lets a shrinking prescale wrap on the next cycle instead of running to overflow
  assign tick    = (presc_q >= prescale_i);
  assign presc_d = tick ? '0 : presc_q + PRESC_W'(1);

`ifdef PWM_CENTER_ALIGNED_EN
  logic dir_q, dir_d;

  always_comb begin
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    boundary = 1'b0;
    if (tick) begin
      if (!dir_q) begin
        if (cnt_q == MAX) begin
          dir_d = 1'b1;
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          dir_d    = 1'b0;
          boundary = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) dir_q <= 1'b0;
    else     dir_q <= dir_d;
  end
`else
  always_comb begin
    cnt_d    = tick ? cnt_q + CNT_W'(1) : cnt_q;
    boundary = tick && (cnt_q == MAX);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q        <= '0;
      cnt_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      presc_q        <= presc_d;
      cnt_q          <= cnt_d;
      period_start_q <= boundary;
    end
  end

  assign cnt_o          = cnt_q;
  assign boundary_o     = boundary;
  assign period_start_o = period_start_q;

endmodule

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM with double-buffered duty/mode applied at period boundaries.
// Build option PWM_CENTER_ALIGNED_EN (in pwm_timebase) switches to centre-aligned counting.
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter int NUM_CH  = NUM_CH_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int PRESC_W = PRESC_W_DEF
) (
  input logic                clk,
  input logic                rst,
  pwm_multi_channel_if.slave bus
);

  localparam logic [CNT_W-1:0] MAX = CNT_W'(cnt_max(CNT_W));

  logic [CNT_W-1:0] cnt;
  logic             boundary;
  logic             period_start;

  pwm_timebase #(
    .CNT_W   (CNT_W),
    .PRESC_W (PRESC_W)
  ) u_timebase (
    .clk            (clk),
    .rst            (rst),
    .prescale_i     (bus.prescale),
    .cnt_o          (cnt),
    .boundary_o     (boundary),
    .period_start_o (period_start)
  );

  logic [CNT_W-1:0] duty_pend_q [NUM_CH];
  logic [CNT_W-1:0] duty_pend_d [NUM_CH];
  logic [CNT_W-1:0] duty_act_q  [NUM_CH];
  logic [CNT_W-1:0] duty_act_d  [NUM_CH];
  pwm_mode_e        mode_pend_q [NUM_CH];
  pwm_mode_e        mode_pend_d [NUM_CH];
  pwm_mode_e        mode_act_q  [NUM_CH];
  pwm_mode_e        mode_act_d  [NUM_CH];
  logic             cfg_pending_q, cfg_pending_d;
  logic [NUM_CH-1:0] pwm_q, pwm_d;
  logic [NUM_CH-1:0] pwm_raw;
  logic             apply;

  // Pending values move to active using the pre-edge pending set, so a load on the boundary waits a period
  assign apply         = boundary && cfg_pending_q;
  assign cfg_pending_d = bus.cfg_load || (cfg_pending_q && !boundary);

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      duty_pend_d[i] = duty_pend_q[i];
      mode_pend_d[i] = mode_pend_q[i];
      duty_act_d[i]  = duty_act_q[i];
      mode_act_d[i]  = mode_act_q[i];
      if (bus.cfg_load) begin
        duty_pend_d[i] = bus.duty[i*CNT_W +: CNT_W];
        mode_pend_d[i] = pwm_mode_e'(bus.en_pwm[i]);
      end
      if (apply) begin
        duty_act_d[i] = duty_pend_q[i];
        mode_act_d[i] = mode_pend_q[i];
      end
      // Full-scale duty is forced high so there is no one-tick low gap at cnt == MAX
      pwm_raw[i] = (duty_act_q[i] == MAX) || (cnt < duty_act_q[i]);
      pwm_d[i]   = bus.en_out[i] && ((mode_act_q[i] == PWM_MODE_PWM) ? pwm_raw[i] : 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        duty_pend_q[i] <= '0;
        mode_pend_q[i] <= PWM_MODE_STATIC;
        duty_act_q[i]  <= '0;
        mode_act_q[i]  <= PWM_MODE_STATIC;
      end
      cfg_pending_q <= 1'b0;
      pwm_q         <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        duty_pend_q[i] <= duty_pend_d[i];
        mode_pend_q[i] <= mode_pend_d[i];
        duty_act_q[i]  <= duty_act_d[i];
        mode_act_q[i]  <= mode_act_d[i];
      end
      cfg_pending_q <= cfg_pending_d;
      pwm_q         <= pwm_d;
    end
  end

  assign bus.cfg_pending  = cfg_pending_q;
  assign bus.period_start = period_start;
  assign bus.pwm_out      = pwm_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Scoreboard bench for pwm_multi_channel (default edge-aligned build).
module tb_pwm_multi_channel;
  import pwm_pkg::*;

  localparam int NUM_CH  = 16;
  localparam int CNT_W   = 8;
  localparam int PRESC_W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pwm_multi_channel_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESC_W(PRESC_W)) bus ();

  pwm_multi_channel #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PRESC_W(PRESC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int    n_checks = 0;
  int    n_pass   = 0;
  string tag_q[$];
  int    exp_q[$];
  int    hi_cnt[NUM_CH];
  int    ps_end;
  int    pend_seen;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic sb_push(input string tag, input int val);
    tag_q.push_back(tag);
    exp_q.push_back(val);
  endtask

  task automatic sb_pop(input int got);
    if (exp_q.size() == 0) begin
      check("sb_underflow", exp_q.size(), 1);
    end else begin
      string t;
      int    e;
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      check(t, got, e);
    end
  endtask

  task automatic set_duty(input int ch, input int d, input logic pwm);
    logic [CNT_W-1:0] dv;
    dv = CNT_W'(d);
    bus.duty[ch*CNT_W +: CNT_W] = dv;
    bus.en_pwm[ch] = pwm;
  endtask

  task automatic pulse_load();
    bus.cfg_load = 1'b1;
    @(negedge clk);
    bus.cfg_load = 1'b0;
  endtask

  // Returns the number of cycles until period_start is seen, 0 on timeout
  task automatic wait_ps(input int budget, output int waited);
    bit found;
    found  = 1'b0;
    waited = 0;
    for (int i = 1; i <= budget && !found; i++) begin
      @(negedge clk);
      if (bus.period_start) begin
        found  = 1'b1;
        waited = i;
      end
    end
  endtask

  task automatic next_boundary(input int budget);
    int w;
    sb_push("ps_found", 1);
    wait_ps(budget, w);
    sb_pop(int'(w != 0));
  endtask

  // Starts at a period_start cycle; optional cfg_load of one channel driven after sample load_idx
  task automatic measure(input int ncyc, input int load_idx, input int load_ch, input int load_duty);
    for (int c = 0; c < NUM_CH; c++) hi_cnt[c] = 0;
    ps_end    = 0;
    pend_seen = 0;
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge clk);
      for (int c = 0; c < NUM_CH; c++) if (bus.pwm_out[c]) hi_cnt[c]++;
      if (i == load_idx + 1) pend_seen = int'(bus.cfg_pending);
      if (i == ncyc) ps_end = int'(bus.period_start);
      bus.cfg_load = (i == load_idx);
      if (i == load_idx) set_duty(load_ch, load_duty, 1'b1);
    end
    bus.cfg_load = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst          = 1'b1;
    bus.cfg_load = 1'b0;
    bus.en_out   = '0;
    bus.en_pwm   = '0;
    bus.duty     = '0;
    bus.prescale = '0;

    // Reset held with random inputs
    for (int k = 0; k < 3; k++) begin
      bus.en_out   = NUM_CH'($urandom);
      bus.en_pwm   = NUM_CH'($urandom);
      bus.duty     = {$urandom, $urandom, $urandom, $urandom};
      bus.prescale = PRESC_W'($urandom);
      bus.cfg_load = 1'($urandom_range(0, 1));
      sb_push("rst_pwm_out", 0);
      sb_push("rst_cfg_pending", 0);
      sb_push("rst_period_start", 0);
      @(negedge clk);
      sb_pop(int'(bus.pwm_out));
      sb_pop(int'(bus.cfg_pending));
      sb_pop(int'(bus.period_start));
    end
    bus.en_out   = '0;
    bus.en_pwm   = '0;
    bus.duty     = '0;
    bus.prescale = '0;
    bus.cfg_load = 1'b0;
    rst          = 1'b0;
    sb_push("first_ps_latency", 256);
    wait_ps(600, w);
    sb_pop(w);

    // Duty 64 on ch0, ch3 static high
    bus.en_out = '1;
    set_duty(0, 64, 1'b1);
    set_duty(3, 0, 1'b0);
    sb_push("pend_after_load", 1);
    pulse_load();
    sb_pop(int'(bus.cfg_pending));
    next_boundary(600);
    sb_push("pend_clr_at_ps", 0);
    sb_pop(int'(bus.cfg_pending));
    sb_push("ch0_duty64", 64);
    sb_push("ch3_static", 256);
    sb_push("period_256", 1);
    measure(256, 0, 0, 0);
    sb_pop(hi_cnt[0]);
    sb_pop(hi_cnt[3]);
    sb_pop(ps_end);

    // Endpoints: duty 0 and full scale
    set_duty(0, 0, 1'b1);
    set_duty(1, 255, 1'b1);
    pulse_load();
    next_boundary(600);
    sb_push("ch0_duty0", 0);
    sb_push("ch1_duty255", 256);
    measure(256, 0, 0, 0);
    sb_pop(hi_cnt[0]);
    sb_pop(hi_cnt[1]);

    // Live output enable
    sb_push("en3_on", 1);
    sb_pop(int'(bus.pwm_out[3]));
    bus.en_out[3] = 1'b0;
    sb_push("en3_off_1clk", 0);
    @(negedge clk);
    sb_pop(int'(bus.pwm_out[3]));
    bus.en_out[3] = 1'b1;
    sb_push("en3_back_1clk", 1);
    @(negedge clk);
    sb_pop(int'(bus.pwm_out[3]));

    // Double buffering: mid-period load does not disturb the running period
    set_duty(0, 32, 1'b1);
    pulse_load();
    next_boundary(600);
    sb_push("ch0_duty32_kept", 32);
    sb_push("pend_mid_period", 1);
    sb_push("period_256_b", 1);
    measure(256, 100, 0, 200);
    sb_pop(hi_cnt[0]);
    sb_pop(pend_seen);
    sb_pop(ps_end);
    sb_push("pend_clr_at_ps_b", 0);
    sb_pop(int'(bus.cfg_pending));
    sb_push("ch0_duty200", 200);
    measure(256, 0, 0, 0);
    sb_pop(hi_cnt[0]);

    // Last write wins
    set_duty(0, 100, 1'b1);
    pulse_load();
    set_duty(0, 150, 1'b1);
    pulse_load();
    next_boundary(600);
    sb_push("ch0_last_write150", 150);
    measure(256, 0, 0, 0);
    sb_pop(hi_cnt[0]);

    // Load coinciding with the boundary
    sb_push("ch0_seg1_150", 100);
    measure(100, 50, 0, 40);
    sb_pop(hi_cnt[0]);
    sb_push("ch0_seg2_150", 50);
    sb_push("pend_stays_on_coincide", 1);
    sb_push("period_256_c", 1);
    measure(156, 155, 0, 90);
    sb_pop(hi_cnt[0]);
    sb_pop(pend_seen);
    sb_pop(ps_end);
    sb_push("ch0_old_pending40", 40);
    measure(256, 0, 0, 0);
    sb_pop(hi_cnt[0]);
    sb_push("pend_clr_after_coincide", 0);
    sb_pop(int'(bus.cfg_pending));
    sb_push("ch0_new_pending90", 90);
    measure(256, 0, 0, 0);
    sb_pop(hi_cnt[0]);

    // Prescaler 3: 1024-clk period, 40 clk high
    bus.prescale = PRESC_W'(3);
    set_duty(0, 10, 1'b1);
    pulse_load();
    next_boundary(2000);
    sb_push("presc3_high40", 40);
    sb_push("presc3_period1024", 1);
    measure(1024, 0, 0, 0);
    sb_pop(hi_cnt[0]);
    sb_pop(ps_end);

    // Prescale shrinks mid-period
    repeat (500) @(negedge clk);
    bus.prescale = '0;
    next_boundary(600);
    sb_push("presc0_high10", 10);
    sb_push("presc0_period256", 1);
    measure(256, 0, 0, 0);
    sb_pop(hi_cnt[0]);
    sb_pop(ps_end);

    // Reset mid-period discards pending update
    set_duty(0, 77, 1'b1);
    pulse_load();
    repeat (20) @(negedge clk);
    rst = 1'b1;
    sb_push("midrst_pwm_out", 0);
    sb_push("midrst_cfg_pending", 0);
    sb_push("midrst_period_start", 0);
    @(negedge clk);
    sb_pop(int'(bus.pwm_out));
    sb_pop(int'(bus.cfg_pending));
    sb_pop(int'(bus.period_start));
    rst = 1'b0;
    sb_push("midrst_first_ps", 256);
    wait_ps(600, w);
    sb_pop(w);
    sb_push("midrst_pending_lost", 256);
    measure(256, 0, 0, 0);
    sb_pop(hi_cnt[0]);

    sb_push("sb_drained", 0);
    sb_pop(exp_q.size() - 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
